bus_controller: RTL

- CPU-side bus control stage in the CPU clock domain. Sits directly upstream of the DRAM controller.
- Decodes each 68000 bus cycle into one-hot chip selects for ROM, DRAM and IO, and produces the chip select the DRAM controller consumes.
- Merges the DRAM controller's DTACK with locally generated wait-state DTACKs into the single DTACK seen by the CPU.
- Handles autovectored interrupt acknowledge and the reset-vector ROM overlay.

---
 rtl/bus_controller_if.sv | 28 ++
 rtl/bus_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_controller_if.sv
// 68000 bus bundle between the CPU, the bus controller and the DRAM controller.
// rw_lat exposes the direction latched with the current cycle.
interface bus_controller_if;
  logic       AS;
  logic       RW;
  logic [2:0] FC;
  logic [7:0] ADDR_IN;
  logic       DTACK_DRAM;
  logic       CS_ROM;
  logic       CS_DRAM;
  logic       CS_IO;
  logic       DTACK;
  logic       VPA;
  logic       BERR;
  logic       rw_lat;

  modport master (
    output AS, RW, FC, ADDR_IN, DTACK_DRAM,
    input  CS_ROM, CS_DRAM, CS_IO,
    input  DTACK, VPA, BERR, rw_lat
  );

  modport slave (
    input  AS, RW, FC, ADDR_IN, DTACK_DRAM,
    output CS_ROM, CS_DRAM, CS_IO,
    output DTACK, VPA, BERR, rw_lat
  );
endinterface

// File: rtl/bus_controller.sv
// 68000 bus control: decode, wait-state DTACK, DRAM DTACK merge, IACK, boot overlay.
// Optional bus-error timeout enabled by defining BUS_TIMEOUT_EN.
module bus_controller #(
  parameter int ROM_WS      = 2,
  parameter int IO_WS       = 4,
  parameter int BOOT_CYCLES = 4
`ifdef BUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic             CLK,
  input logic             RST,
  bus_controller_if.slave bus
);
  localparam int BW = $clog2(BOOT_CYCLES + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef enum logic [2:0] {
    R_NONE, R_IACK, R_ROM, R_IO, R_DRAM
  } region_t;

  state_t        state_q, state_d;
  region_t       region_q, region_d, dec;
  logic          rw_q, rw_d;
  logic [7:0]    wait_q, wait_d;
  logic [BW-1:0] boot_q, boot_d;
  logic          dd1, dd2;
  logic          cs_rom_q, cs_rom_d;
  logic          cs_dram_q, cs_dram_d;
  logic          cs_io_q, cs_io_d;
  logic          dtack_q, dtack_d;
  logic          vpa_q, vpa_d;
  logic          dtack_hit;
  logic          overlay;
  logic          iack, low0;
  logic          rom_hit, io_hit, dram_hit;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]    to_q, to_d;
  logic          berr_q, berr_d;
`endif

  assign overlay = boot_q != BW'(BOOT_CYCLES);
  assign iack    = bus.FC == 3'b111;
  assign low0    = overlay && bus.ADDR_IN == 8'h00;

  // Hits are made mutually exclusive so the decoder stays one-hot.
  assign rom_hit  = !iack &&
    (bus.ADDR_IN[7:2] == 6'b111100 || low0);
  assign io_hit   = !iack && bus.ADDR_IN == 8'hFF;
  assign dram_hit = !iack && !low0 &&
    bus.ADDR_IN < 8'hE0;

  always_comb begin
    dec = R_NONE;
    unique case (1'b1)
      iack:     dec = R_IACK;
      rom_hit:  dec = R_ROM;
      io_hit:   dec = R_IO;
      dram_hit: dec = R_DRAM;
      default:  dec = R_NONE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    rw_d      = rw_q;
    wait_d    = wait_q;
    boot_d    = boot_q;
    cs_rom_d  = cs_rom_q;
    cs_dram_d = cs_dram_q;
    cs_io_d   = cs_io_q;
    dtack_d   = dtack_q;
    vpa_d     = vpa_q;
    dtack_hit = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to_d      = to_q;
    berr_d    = berr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!bus.AS) begin
          state_d   = ACTIVE;
          region_d  = dec;
          rw_d      = bus.RW;
          wait_d    = '0;
          cs_rom_d  = dec != R_ROM;
          cs_dram_d = dec != R_DRAM;
          cs_io_d   = dec != R_IO;
          vpa_d     = dec != R_IACK;
`ifdef BUS_TIMEOUT_EN
          to_d      = '0;
`endif
        end
      end
      ACTIVE: begin
        if (bus.AS) begin
          // End of cycle wins over any DTACK condition this edge.
          state_d   = IDLE;
          cs_rom_d  = 1'b1;
          cs_dram_d = 1'b1;
          cs_io_d   = 1'b1;
          dtack_d   = 1'b1;
          vpa_d     = 1'b1;
`ifdef BUS_TIMEOUT_EN
          berr_d    = 1'b1;
`endif
          if (overlay)
            boot_d = boot_q + 1'b1;
        end else begin
          if (dtack_q)
            wait_d = wait_q + 1'b1;
          unique case (region_q)
            R_ROM:   dtack_hit = wait_q == 8'(ROM_WS - 1);
            R_IO:    dtack_hit = wait_q == 8'(IO_WS - 1);
            R_DRAM:  dtack_hit = !dd2;
            default: dtack_hit = 1'b0;
          endcase
`ifdef BUS_TIMEOUT_EN
          if (dtack_q && vpa_q && to_q != 8'hFF)
            to_d = to_q + 1'b1;
          berr_d = berr_q &&
            to_d != 8'(TIMEOUT_CYCLES);
          if (!berr_d)
            dtack_hit = 1'b0;
`endif
          if (dtack_hit)
            dtack_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      region_q  <= R_NONE;
      rw_q      <= 1'b1;
      wait_q    <= '0;
      boot_q    <= '0;
      dd1       <= 1'b1;
      dd2       <= 1'b1;
      cs_rom_q  <= 1'b1;
      cs_dram_q <= 1'b1;
      cs_io_q   <= 1'b1;
      dtack_q   <= 1'b1;
      vpa_q     <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      to_q      <= '0;
      berr_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      rw_q      <= rw_d;
      wait_q    <= wait_d;
      boot_q    <= boot_d;
      dd1       <= bus.DTACK_DRAM;
      dd2       <= dd1;
      cs_rom_q  <= cs_rom_d;
      cs_dram_q <= cs_dram_d;
      cs_io_q   <= cs_io_d;
      dtack_q   <= dtack_d;
      vpa_q     <= vpa_d;
`ifdef BUS_TIMEOUT_EN
      to_q      <= to_d;
      berr_q    <= berr_d;
`endif
    end
  end

  assign bus.CS_ROM  = cs_rom_q;
  assign bus.CS_DRAM = cs_dram_q;
  assign bus.CS_IO   = cs_io_q;
  assign bus.DTACK   = dtack_q;
  assign bus.VPA     = vpa_q;
  assign bus.rw_lat  = rw_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.BERR    = berr_q;
`else
  assign bus.BERR    = 1'b1;
`endif
endmodule
